// File: rtl/formula_loader.sv
// formula_loader: assembles a stream of narrow coefficient words into full
// clause records and writes them, one strobe per clause, into clause slots.
// Ports:
//   in_clk, in_reset (sync, active-low)      clock and reset
//   in_start, in_num_clauses                 begin a formula of N clauses
//   in_word, in_word_valid / out_word_ready  coefficient stream handshake
//   out_clause_index, out_clause_coefficients_integer/_boolean,
//   out_write_enable                         clause register write port
//   out_checker_enable                       per-slot "clause loaded" mask
//   out_busy, out_done                       load status
module formula_loader #(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 3,
  parameter int unsigned IN_WORD_WIDTH                               = 4,
  localparam int unsigned CI    = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int unsigned NC    = 2 ** CI,
  localparam int unsigned NI    = 2 ** MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
  localparam int unsigned NB    = 2 ** MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
  localparam int unsigned INT_W = (NI + 1) * MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
  localparam int unsigned BOOL_W = NB * MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_start,
  input  logic [CI:0]              in_num_clauses,
  input  logic [IN_WORD_WIDTH-1:0] in_word,
  input  logic                     in_word_valid,
  output logic                     out_word_ready,
  output logic [CI-1:0]            out_clause_index,
  output logic [INT_W-1:0]         out_clause_coefficients_integer,
  output logic [BOOL_W-1:0]        out_clause_coefficients_boolean,
  output logic                     out_write_enable,
  output logic [NC-1:0]            out_checker_enable,
  output logic                     out_busy,
  output logic                     out_done
);

  localparam int unsigned IW    = IN_WORD_WIDTH;
  localparam int unsigned R     = INT_W + BOOL_W;
  localparam int unsigned WPC   = (R + IW - 1) / IW;
  localparam int unsigned ASM_W = WPC * IW;
  localparam int unsigned WC_W  = (WPC > 1) ? $clog2(WPC) : 1;
  localparam logic [CI:0]   NC_V       = (CI + 1)'(NC);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WPC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic [CI:0]          n_q, n_d, n_clamp;
  logic [CI-1:0]        clause_cnt_q, clause_cnt_d;
  logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
  logic [ASM_W-1:0]     asm_q, asm_d;
  logic [NC-1:0]        ce_q, ce_d;
  logic [CI-1:0]        idx_q, idx_d;
  logic [INT_W-1:0]     int_q, int_d;
  logic [BOOL_W-1:0]    bool_q, bool_d;
  logic                 ready_q, we_q, busy_q, done_q;

  // Next-state, datapath and counter update
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    clause_cnt_d = clause_cnt_q;
    word_cnt_d   = word_cnt_q;
    asm_d        = asm_q;
    ce_d         = ce_q;
    idx_d        = idx_q;
    int_d        = int_q;
    bool_d       = bool_q;
    n_clamp      = (in_num_clauses > NC_V) ? NC_V : in_num_clauses;
    unique case (state_q)
      IDLE, DONE: begin
        if (in_start) begin
          n_d          = n_clamp;
          clause_cnt_d = '0;
          word_cnt_d   = '0;
          asm_d        = '0;
          ce_d         = '0;
          state_d      = (n_clamp == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        // ready is high for the whole LOAD state, so valid alone accepts
        if (in_word_valid) begin
          asm_d[int'(word_cnt_q) * IW +: IW] = in_word;
          if (word_cnt_q == LAST_WORD) begin
            // capture the completed clause into the held output registers
            state_d = WRITE;
            idx_d   = clause_cnt_q;
            int_d   = asm_d[INT_W-1:0];
            bool_d  = asm_d[R-1:INT_W];
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        ce_d[clause_cnt_q] = 1'b1;
        if ({1'b0, clause_cnt_q} == n_q - 1'b1) begin
          state_d = DONE;
        end else begin
          clause_cnt_d = clause_cnt_q + 1'b1;
          word_cnt_d   = '0;
          state_d      = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; status outputs decode the next state
  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      clause_cnt_q <= '0;
      word_cnt_q   <= '0;
      asm_q        <= '0;
      ce_q         <= '0;
      idx_q        <= '0;
      int_q        <= '0;
      bool_q       <= '0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      clause_cnt_q <= clause_cnt_d;
      word_cnt_q   <= word_cnt_d;
      asm_q        <= asm_d;
      ce_q         <= ce_d;
      idx_q        <= idx_d;
      int_q        <= int_d;
      bool_q       <= bool_d;
      ready_q      <= (state_d == LOAD);
      we_q         <= (state_d == WRITE);
      busy_q       <= (state_d == LOAD) || (state_d == WRITE);
      done_q       <= (state_d == DONE);
    end
  end

  assign out_word_ready                  = ready_q;
  assign out_clause_index                = idx_q;
  assign out_clause_coefficients_integer = int_q;
  assign out_clause_coefficients_boolean = bool_q;
  assign out_write_enable                = we_q;
  assign out_checker_enable              = ce_q;
  assign out_busy                        = busy_q;
  assign out_done                        = done_q;

endmodule

// File: tb/tb_formula_loader.sv
// Directed bench for formula_loader (default parameters). Stimulus pushes the
// expected clause writes into a queue; a negedge monitor pops and compares on
// every write strobe.
module tb_formula_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  num;
  logic [3:0]  word;
  logic        valid;
  logic        ready;
  logic [2:0]  idx;
  logic [11:0] c_int;
  logic [3:0]  c_bool;
  logic        we;
  logic [7:0]  ce;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [2:0]  idx;
    logic [11:0] ci;
    logic [3:0]  cb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   strobes = 0;

  formula_loader dut (
    .in_clk                          (clk),
    .in_reset                        (rst_n),
    .in_start                        (start),
    .in_num_clauses                  (num),
    .in_word                         (word),
    .in_word_valid                   (valid),
    .out_word_ready                  (ready),
    .out_clause_index                (idx),
    .out_clause_coefficients_integer (c_int),
    .out_clause_coefficients_boolean (c_bool),
    .out_write_enable                (we),
    .out_checker_enable              (ce),
    .out_busy                        (busy),
    .out_done                        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Monitor: every write strobe must match the oldest expected clause
  always @(negedge clk) begin
    if (rst_n && we) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, idx}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_index", {29'd0, idx}, {29'd0, e.idx});
        check("wr_int", {20'd0, c_int}, {20'd0, e.ci});
        check("wr_bool", {28'd0, c_bool}, {28'd0, e.cb});
      end
    end
  end

  task automatic do_start(input logic [3:0] n);
    start = 1'b1;
    num   = n;
    tick();
    start = 1'b0;
  endtask

  // Feeds one 16-bit clause as four words (word 0 = low nibble), optionally
  // stalling before word stall_at and pulsing in_start alongside word 1.
  task automatic send_clause(input logic [15:0] r, input int stall_at, input int stall_len,
                             input bit poke_start);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_ready", {31'd0, ready}, 32'd1);
          check("stall_no_we", {31'd0, we}, 32'd0);
        end
      end
      word  = r[k*4 +: 4];
      valid = 1'b1;
      if (poke_start && k == 1) begin
        start = 1'b1;
        num   = 4'd0;
      end
      tick();
      start = 1'b0;
    end
    valid = 1'b0;
  endtask

  // Expects a write of clause r at index i, then spends the WRITE cycle
  task automatic clause(input logic [2:0] i, input logic [15:0] r, input int stall_at,
                        input int stall_len, input bit poke_start);
    exp_t e;
    e.idx = i;
    e.ci  = r[11:0];
    e.cb  = r[15:12];
    exp_q.push_back(e);
    send_clause(r, stall_at, stall_len, poke_start);
    check("we_in_write", {31'd0, we}, 32'd1);
    tick();
  endtask

  initial begin
    int c0;
    int s0;
    start = 1'b0; num = '0; word = '0; valid = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ce", {24'd0, ce}, 32'd0);
    check("rst_int", {20'd0, c_int}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single clause 0x1,0x2,0x3,0x4
    do_start(4'd1);
    c0 = cyc;
    check("t1_ready", {31'd0, ready}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    clause(3'd0, 16'h4321, -1, 0, 1'b0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_cycles", cyc - c0, 32'd5);
    check("t1_ce", {24'd0, ce}, 32'h01);
    check("t1_hold_int", {20'd0, c_int}, 32'h321);
    check("t1_busy_off", {31'd0, busy}, 32'd0);

    // Three clauses, continuous valid
    do_start(4'd3);
    c0 = cyc;
    check("t2_ce_cleared", {24'd0, ce}, 32'h00);
    clause(3'd0, 16'hA5C3, -1, 0, 1'b0);
    clause(3'd1, 16'h0F1E, -1, 0, 1'b0);
    clause(3'd2, 16'h96B7, -1, 0, 1'b0);
    check("t2_cycles", cyc - c0, 32'd15);
    check("t2_ce", {24'd0, ce}, 32'h07);
    tick(); tick();
    check("t2_done_held", {31'd0, done}, 32'd1);
    check("t2_ce_held", {24'd0, ce}, 32'h07);
    check("t2_we_idle", {31'd0, we}, 32'd0);

    // Two clauses, valid dropped for 3 cycles before the third word
    do_start(4'd2);
    c0 = cyc;
    clause(3'd0, 16'h1234, 2, 3, 1'b0);
    clause(3'd1, 16'hFEDC, -1, 0, 1'b0);
    check("t3_cycles", cyc - c0, 32'd13);
    check("t3_ce", {24'd0, ce}, 32'h03);

    // Zero clauses: straight to DONE, no strobe
    s0 = strobes;
    do_start(4'd0);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_ce", {24'd0, ce}, 32'h00);
    tick();
    check("t4_no_strobe", strobes - s0, 32'd0);

    // Fifteen clauses clamp to eight
    do_start(4'd15);
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      clause(3'(i), 16'(16'h1111 * (i + 1) + 16'(i)), -1, 0, 1'b0);
    check("t5_cycles", cyc - c0, 32'd40);
    check("t5_ce", {24'd0, ce}, 32'hFF);
    check("t5_done", {31'd0, done}, 32'd1);

    // Reset after two words of clause 1
    do_start(4'd2);
    clause(3'd0, 16'h5A5A, -1, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      word = 4'(k + 7); valid = 1'b1; tick();
    end
    valid = 1'b0;
    s0 = strobes;
    rst_n = 1'b0;
    tick();
    check("t6_ready", {31'd0, ready}, 32'd0);
    check("t6_idx", {29'd0, idx}, 32'd0);
    check("t6_int", {20'd0, c_int}, 32'd0);
    check("t6_bool", {28'd0, c_bool}, 32'd0);
    check("t6_ce", {24'd0, ce}, 32'd0);
    check("t6_busy_done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("t6_no_strobe", strobes - s0, 32'd0);
    do_start(4'd1);
    clause(3'd0, 16'hC0DE, -1, 0, 1'b0);
    check("t6_reload_ce", {24'd0, ce}, 32'h01);

    // Start pulsed during LOAD is ignored; start in DONE restarts
    do_start(4'd2);
    c0 = cyc;
    clause(3'd0, 16'h8421, -1, 0, 1'b1);
    clause(3'd1, 16'h7BDE, -1, 0, 1'b0);
    check("t7_cycles", cyc - c0, 32'd10);
    check("t7_ce", {24'd0, ce}, 32'h03);
    do_start(4'd1);
    check("t7_restart_ce", {24'd0, ce}, 32'h00);
    check("t7_restart_done", {31'd0, done}, 32'd0);
    check("t7_restart_busy", {31'd0, busy}, 32'd1);
    clause(3'd0, 16'h0001, -1, 0, 1'b0);
    check("t7_final_ce", {24'd0, ce}, 32'h01);

    tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
